sm4_frame_tx: RTL and testbench

Input framer for the SM4 core. It accepts plaintext/key blocks from an upstream valid/ready source and buffers one complete message of up to DEPTH blocks. It then replays the message onto the SM4 core's framed input port: a one-cycle `start_input` pulse, followed by a gap-free burst of `datain`/`mkin` beats, with `end_input` on the last beat. It sits directly in front of the SM4 top-level and produces exactly the framing that top-level consumes.

---
 rtl/sm4_frame_tx.sv | 118 +++++++++++
 tb/tb_sm4_frame_tx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sm4_frame_tx.sv
// Message buffer and replay framer in front of the SM4 core: collects up to DEPTH
// {key,data} blocks, then emits start_input, a gap-free beat burst and end_input.
module sm4_frame_tx #(
   parameter int DEPTH = 8
) (
   input  logic         i_clk,
   input  logic         i_rstn,
   input  logic         i_s_valid,
   output logic         o_s_ready,
   input  logic [127:0] i_s_data,
   input  logic [127:0] i_s_key,
   input  logic         i_s_last,
   output logic         o_start_input,
   output logic         o_end_input,
   output logic [127:0] o_datain,
   output logic [127:0] o_mkin,
   output logic         o_busy,
   output logic         o_err_ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [1:0] ST_FILL  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_BURST = 2'd2;

   logic [1:0]    r_state;
   logic [CW-1:0] r_wcnt;
   logic [CW-1:0] r_rptr;
   logic          r_start;
   logic          r_end;
   logic [127:0]  r_datain;
   logic [127:0]  r_mkin;
   logic          r_busy;
   logic          r_ovf;
   logic [255:0]  r_mem [DEPTH];

   logic          w_xfer;
   logic          w_full;
   logic          w_close;

   assign o_s_ready = (r_state == ST_FILL);
   assign w_xfer    = i_s_valid && o_s_ready;
   assign w_full    = (r_wcnt == CW'(DEPTH - 1));
   assign w_close   = w_xfer && (i_s_last || w_full);

   always_ff @(posedge i_clk) begin
      if (w_xfer) begin
         r_mem[r_wcnt[AW-1:0]] <= {i_s_key, i_s_data};
      end
   end

   // Output registers are loaded one edge ahead: r_rptr always names the next beat to fetch.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state  <= ST_FILL;
         r_wcnt   <= '0;
         r_rptr   <= '0;
         r_start  <= 1'b0;
         r_end    <= 1'b0;
         r_datain <= '0;
         r_mkin   <= '0;
         r_busy   <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         r_start <= 1'b0;
         r_ovf   <= 1'b0;
         case (r_state)
            ST_FILL: begin
               if (w_xfer) begin
                  r_wcnt <= r_wcnt + CW'(1);
                  if (w_close) begin
                     r_state <= ST_START;
                     r_start <= 1'b1;
                     r_ovf   <= !i_s_last;
                     r_busy  <= 1'b1;
                     r_rptr  <= '0;
                  end
               end
            end
            ST_START: begin
               r_state             <= ST_BURST;
               {r_mkin, r_datain}  <= r_mem[r_rptr[AW-1:0]];
               r_end               <= (r_wcnt == CW'(1));
               r_rptr              <= r_rptr + CW'(1);
            end
            ST_BURST: begin
               if (r_end) begin
                  r_state  <= ST_FILL;
                  r_end    <= 1'b0;
                  r_datain <= '0;
                  r_mkin   <= '0;
                  r_wcnt   <= '0;
                  r_rptr   <= '0;
                  r_busy   <= 1'b0;
               end else begin
                  {r_mkin, r_datain} <= r_mem[r_rptr[AW-1:0]];
                  r_end              <= (r_rptr == r_wcnt - CW'(1));
                  r_rptr             <= r_rptr + CW'(1);
               end
            end
            default: begin
               r_state <= ST_FILL;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_start_input = r_start;
   assign o_end_input   = r_end;
   assign o_datain      = r_datain;
   assign o_mkin        = r_mkin;
   assign o_busy        = r_busy;
   assign o_err_ovf     = r_ovf;

endmodule

// File: tb/tb_sm4_frame_tx.sv
// Directed bench for sm4_frame_tx: driver pushes expected frames into a scoreboard,
// a negedge monitor pops and compares whatever the framer presents each cycle.
module tb_sm4_frame_tx;

   localparam int DEPTH = 8;

   logic         clk = 1'b0;
   logic         rstn;
   logic         s_valid;
   logic         s_ready;
   logic [127:0] s_data;
   logic [127:0] s_key;
   logic         s_last;
   logic         start_input;
   logic         end_input;
   logic [127:0] datain;
   logic [127:0] mkin;
   logic         busy;
   logic         err_ovf;

   sm4_frame_tx #(.DEPTH(DEPTH)) dut (
      .i_clk        (clk),
      .i_rstn       (rstn),
      .i_s_valid    (s_valid),
      .o_s_ready    (s_ready),
      .i_s_data     (s_data),
      .i_s_key      (s_key),
      .i_s_last     (s_last),
      .o_start_input(start_input),
      .o_end_input  (end_input),
      .o_datain     (datain),
      .o_mkin       (mkin),
      .o_busy       (busy),
      .o_err_ovf    (err_ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit           is_start;
      bit           ovf;
      longint       cyc;
      logic [127:0] d;
      logic [127:0] k;
      bit           last;
   } item_t;

   item_t        sb[$];
   logic [255:0] pending[$];
   longint       cyc = 0;
   longint       last_edge = 0;
   longint       last_n = 0;
   int           n_vec = 0;
   int           n_err = 0;
   bit           in_burst = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [260:0] outs();
      return {start_input, end_input, busy, err_ovf, s_ready, datain, mkin};
   endfunction

   // Monitor: start is expected on the cycle the driver predicted, beats follow back to back.
   initial begin
      item_t it;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            sb.delete();
            in_burst = 0;
            chk("reset_outputs", outs(), {5'b00001, 256'b0});
         end else if (in_burst) begin
            if (sb.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL beat: got unexpected burst cycle expected no beat");
               in_burst = 0;
            end else begin
               it = sb.pop_front();
               chk("beat", outs(), {1'b0, it.last, 1'b1, 1'b0, 1'b0, it.d, it.k});
               if (it.last) in_burst = 0;
            end
         end else if (sb.size() > 0 && sb[0].is_start && cyc == sb[0].cyc) begin
            it = sb.pop_front();
            chk("start", outs(), {1'b1, 1'b0, 1'b1, it.ovf, 1'b0, 256'b0});
            in_burst = 1;
         end else begin
            chk("idle", outs(), {5'b00001, 256'b0});
         end
      end
   end

   task automatic push_block(input logic [127:0] d, input logic [127:0] k,
                             input bit last, input longint exp_edge);
      item_t it;
      bit    got;
      longint edge_n;
      s_data  = d;
      s_key   = k;
      s_last  = last;
      s_valid = 1'b1;
      got = 0;
      for (int w = 0; w < 200 && !got; w++) begin
         @(negedge clk);
         if (s_ready) got = 1;
      end
      if (!got) begin
         n_vec++; n_err++;
         $display("FAIL xfer_timeout: got no s_ready expected transfer");
         return;
      end
      edge_n = cyc + 1;
      if (exp_edge != 0) chk("xfer_edge", 384'(edge_n), 384'(exp_edge));
      pending.push_back({k, d});
      if (last || pending.size() == DEPTH) begin
         it = '{is_start: 1, ovf: !last, cyc: edge_n, d: '0, k: '0, last: 0};
         sb.push_back(it);
         for (int i = 0; i < pending.size(); i++) begin
            it = '{is_start: 0, ovf: 0, cyc: 0, d: pending[i][127:0],
                   k: pending[i][255:128], last: (i == pending.size() - 1)};
            sb.push_back(it);
         end
         last_edge = edge_n;
         last_n    = pending.size();
         pending.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_gap(input int n);
      s_valid = 1'b0;
      s_last  = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [127:0] d;
      rstn    = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      s_key   = '0;
      s_last  = 1'b0;
      #1;
      chk("reset_immediate", outs(), {5'b00001, 256'b0});
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      idle_gap(2);

      // two-block message
      push_block({16{8'h01}}, {16{8'h10}}, 0, 0);
      push_block(128'h0123456789abcdeffedcba9876543210, {16{8'h10}}, 1, 0);
      idle_gap(6);

      // single block
      push_block(128'hdeadbeef_00112233_44556677_8899aabb, 128'h0f0e0d0c_0b0a0908_07060504_03020100, 1, 0);
      idle_gap(5);

      // overflow: DEPTH blocks, none marked last
      for (int i = 0; i < DEPTH; i++) begin
         d = {16{8'(8'h30 + i)}};
         push_block(d, ~d, 0, 0);
      end
      idle_gap(12);

      // upstream gaps, then valid held through START/BURST
      push_block(128'h1111, 128'ha1, 0, 0);
      idle_gap(2);
      push_block(128'h2222, 128'ha2, 0, 0);
      idle_gap(1);
      push_block(128'h3333, 128'ha3, 1, 0);
      push_block(128'h4444, 128'ha4, 1, last_edge + last_n + 2);
      idle_gap(5);

      // reset during beat 1 of a 4-block burst
      for (int i = 0; i < 4; i++) push_block(128'(32'h5000 + i), 128'(32'hb000 + i), i == 3, 0);
      s_valid = 1'b0;
      s_last  = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rstn = 1'b0;
      #1 chk("async_reset_midburst", outs(), {5'b00001, 256'b0});
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      idle_gap(1);
      push_block(128'h6000, 128'hc000, 0, 0);
      push_block(128'h6001, 128'hc001, 1, 0);
      idle_gap(6);

      // back-to-back: 2 then 3 blocks, valid never dropped
      push_block(128'h7000, 128'hd000, 0, 0);
      push_block(128'h7001, 128'hd001, 1, 0);
      push_block(128'h7100, 128'hd100, 0, last_edge + last_n + 2);
      push_block(128'h7101, 128'hd101, 0, 0);
      push_block(128'h7102, 128'hd102, 1, 0);
      idle_gap(1);

      for (int w = 0; w < 100 && (sb.size() != 0 || in_burst); w++) @(posedge clk);
      idle_gap(2);
      chk("scoreboard_drained", 384'(sb.size()), 384'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
